// File: rtl/fp_add_sub_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_add_sub_arbiter                                         |
// | Description : Round-robin sharing of one add/sub FPU between requesters, |
// |               with an ID pipeline and a credit-protected response FIFO.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fp_add_sub_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int LATENCY   = 1,
    parameter int RSP_DEPTH = 4,
    parameter bit ADD_SEL   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    input  logic [NUM_REQ-1:0]           req_op,
    output logic [WIDTH-1:0]             fpu_a,
    output logic [WIDTH-1:0]             fpu_b,
    output logic                         fpu_op,
    input  logic [WIDTH-1:0]             fpu_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]             rsp_result,
    output logic                         rsp_nan,
    output logic                         rsp_inf,
    output logic                         busy
);

    localparam int c_ID_W    = $clog2(NUM_REQ);
    localparam int c_PTR_W   = $clog2(RSP_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_OUT_W   = c_CNT_W + $clog2(LATENCY + 1);
    localparam int c_EXP_MSB = 30;
    localparam int c_EXP_LSB = 23;
    localparam int c_MAN_MSB = 22;

    logic [c_ID_W-1:0]               ptr_q, ptr_d;
    logic [WIDTH-1:0]                fpu_a_q, fpu_b_q;
    logic                            fpu_op_q;
    logic [LATENCY-1:0]              stg_vld_q;
    logic [LATENCY-1:0][c_ID_W-1:0]  stg_id_q;

    logic [c_ID_W-1:0]               mem_id_q  [RSP_DEPTH];
    logic [WIDTH-1:0]                mem_res_q [RSP_DEPTH];
    logic                            mem_nan_q [RSP_DEPTH];
    logic                            mem_inf_q [RSP_DEPTH];
    logic [c_PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0]              cnt_q;

    logic [c_OUT_W-1:0]              w_outstanding;
    logic                            w_can_issue;
    logic                            w_grant_vld;
    logic [c_ID_W-1:0]               w_grant_idx;
    logic [c_ID_W:0]                 w_cand;
    logic                            w_issue;
    logic [WIDTH-1:0]                w_sel_a, w_sel_b;
    logic                            w_sel_op;
    logic                            w_push, w_pop;
    logic                            w_nan, w_inf;

    // Credit: pops in the current cycle are deliberately not counted.
    always_comb begin
        w_outstanding = c_OUT_W'(cnt_q);
        for (int s = 0; s < LATENCY; s++) begin
            w_outstanding = w_outstanding + c_OUT_W'(stg_vld_q[s]);
        end
    end

    assign w_can_issue = (w_outstanding < c_OUT_W'(RSP_DEPTH));
    assign busy        = (w_outstanding != '0);

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr_q} + (c_ID_W+1)'(k);
            if (w_cand >= (c_ID_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (c_ID_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && req_valid[w_cand[c_ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand[c_ID_W-1:0];
            end
        end
    end

    assign w_issue = w_can_issue & w_grant_vld;

    always_comb begin
        req_ready = '0;
        if (w_issue) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == c_ID_W'(i)) begin
                w_sel_a  = req_a[i*WIDTH +: WIDTH];
                w_sel_b  = req_b[i*WIDTH +: WIDTH];
                w_sel_op = (req_op[i] == ADD_SEL) ? ADD_SEL : ~ADD_SEL;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_issue) begin
            ptr_d = (w_grant_idx == c_ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + c_ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            fpu_op_q  <= 1'b0;
            stg_vld_q <= '0;
            stg_id_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            stg_vld_q[0] <= w_issue;
            stg_id_q[0]  <= w_grant_idx;
            if (w_issue) begin
                fpu_a_q  <= w_sel_a;
                fpu_b_q  <= w_sel_b;
                fpu_op_q <= w_sel_op;
            end
            for (int s = 1; s < LATENCY; s++) begin
                stg_vld_q[s] <= stg_vld_q[s-1];
                stg_id_q[s]  <= stg_id_q[s-1];
            end
        end
    end

    assign fpu_a  = fpu_a_q;
    assign fpu_b  = fpu_b_q;
    assign fpu_op = fpu_op_q;

    // The last ID stage lines up with the cycle fpu_result is valid.
    assign w_push    = stg_vld_q[LATENCY-1];
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_nan     = (&fpu_result[c_EXP_MSB:c_EXP_LSB]) & (|fpu_result[c_MAN_MSB:0]);
    assign w_inf     = (&fpu_result[c_EXP_MSB:c_EXP_LSB]) & ~(|fpu_result[c_MAN_MSB:0]);
    assign rsp_valid = (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + c_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - c_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_id_q[wr_ptr_q]  <= stg_id_q[LATENCY-1];
            mem_res_q[wr_ptr_q] <= fpu_result;
            mem_nan_q[wr_ptr_q] <= w_nan;
            mem_inf_q[wr_ptr_q] <= w_inf;
        end
    end

    // Gate the head with rsp_valid so an empty FIFO presents all-zero fields.
    assign rsp_id     = rsp_valid ? mem_id_q[rd_ptr_q]  : '0;
    assign rsp_result = rsp_valid ? mem_res_q[rd_ptr_q] : '0;
    assign rsp_nan    = rsp_valid ? mem_nan_q[rd_ptr_q] : 1'b0;
    assign rsp_inf    = rsp_valid ? mem_inf_q[rd_ptr_q] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sub_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fp_add_sub_arbiter                                      |
// | Description : Directed self-checking bench for fp_add_sub_arbiter.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fp_add_sub_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int D   = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_op;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   fpu_a, fpu_b, fpu_result, rsp_result;
    logic           fpu_op, rsp_valid, rsp_ready, rsp_nan, rsp_inf, busy;
    logic [1:0]     rsp_id;

    int tests = 0;
    int fails = 0;

    fp_add_sub_arbiter #(
        .WIDTH(W), .NUM_REQ(N), .LATENCY(LAT), .RSP_DEPTH(D), .ADD_SEL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_nan(rsp_nan), .rsp_inf(rsp_inf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for add_sub_main: exact answers for the directed vectors,
    // NaN/Inf propagation, and a distinguishable pattern otherwise.
    function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                             input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && op)  return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h3F800000 && !op) return 32'h40000000;
        if (a[30:23] == 8'hFF) return a;
        return a ^ b;
    endfunction

    always_comb fpu_result = fake_fpu(fpu_a, fpu_b, fpu_op);

    function automatic logic [31:0] opa(input int r);
        return 32'h1100_0A00 * 32'(r + 1);
    endfunction
    function automatic logic [31:0] opb(input int r);
        return 32'h0000_0055 + 32'(r);
    endfunction
    function automatic logic opop(input int r);
        return (r % 2) == 1;
    endfunction

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic op);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_op[r]       = op;
    endtask

    task automatic set_all_req();
        for (int r = 0; r < N; r++) set_req(r, opa(r), opb(r), opop(r));
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (fpu_a !== 32'h0) begin fails++; $display("FAIL reset_fpu_a: got %h exp %h", fpu_a, 32'h0); end
        tests++; if (fpu_b !== 32'h0) begin fails++; $display("FAIL reset_fpu_b: got %h exp %h", fpu_b, 32'h0); end
        tests++; if (fpu_op !== 1'b0) begin fails++; $display("FAIL reset_fpu_op: got %b exp 0", fpu_op); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        tests++; if (rsp_id !== 2'd0 || rsp_result !== 32'h0) begin fails++; $display("FAIL reset_rsp_fields: got id %0d res %h exp 0 0", rsp_id, rsp_result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b1);
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL t1_ready: got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000 || fpu_op !== 1'b1) begin fails++; $display("FAIL t1_fpu_regs: got %h %h %b exp 3f800000 40000000 1", fpu_a, fpu_b, fpu_op); end
        tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL t1_inflight: got busy %b rsp_valid %b exp 1 0", busy, rsp_valid); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin fails++; $display("FAIL t1_rsp: got valid %b id %0d exp 1 0", rsp_valid, rsp_id); end
        tests++; if (rsp_result !== 32'h40400000) begin fails++; $display("FAIL t1_result: got %h exp 40400000", rsp_result); end
        tests++; if (rsp_nan !== 1'b0 || rsp_inf !== 1'b0) begin fails++; $display("FAIL t1_flags: got nan %b inf %b exp 0 0", rsp_nan, rsp_inf); end
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL t1_idle: got busy %b rsp_valid %b exp 0 0", busy, rsp_valid); end
    endtask

    task automatic test_sub_req2();
        @(negedge clk);
        set_req(2, 32'h40400000, 32'h3F800000, 1'b0);
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL t2_ready: got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin fails++; $display("FAIL t2_rsp: got valid %b id %0d exp 1 2", rsp_valid, rsp_id); end
        tests++; if (rsp_result !== 32'h40000000) begin fails++; $display("FAIL t2_result: got %h exp 40000000", rsp_result); end
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t2_idle: got busy %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int r;
        do_reset();
        set_all_req();
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = (c < 6) ? 4'hF : 4'h0;
            #1;
            exp_rdy = (c < 6) ? (4'b0001 << (c % 4)) : 4'b0000;
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready c=%0d: got %b exp %b", c, req_ready, exp_rdy); end
            if (c >= 2) begin
                r = (c - 2) % 4;
                tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(r)) begin fails++; $display("FAIL rr_rsp c=%0d: got valid %b id %0d exp 1 %0d", c, rsp_valid, rsp_id, r); end
                tests++; if (rsp_result !== fake_fpu(opa(r), opb(r), opop(r))) begin fails++; $display("FAIL rr_result c=%0d: got %h exp %h", c, rsp_result, fake_fpu(opa(r), opb(r), opop(r))); end
            end
        end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rr_idle: got valid %b busy %b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy;
        do_reset();
        set_all_req();
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 4'hF;
            if (c == 5) rsp_ready = 1'b1;
            #1;
            exp_rdy = (c < 4) ? (4'b0001 << c) : 4'b0000;
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL bp_ready c=%0d: got %b exp %b", c, req_ready, exp_rdy); end
            if (c >= 4) begin
                tests++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_id !== 2'd0) begin fails++; $display("FAIL bp_full c=%0d: got valid %b busy %b id %0d exp 1 1 0", c, rsp_valid, busy, rsp_id); end
            end
        end
        @(negedge clk);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_resume: got %b exp 0001", req_ready); end
        req_valid = '0;
        for (int k = 1; k < 4; k++) begin
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k)) begin fails++; $display("FAIL bp_drain k=%0d: got valid %b id %0d exp 1 %0d", k, rsp_valid, rsp_id, k); end
            @(negedge clk);
            #1;
        end
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_empty: got valid %b busy %b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_flags();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 32'h7FC00000, 32'h3F800000, 1'b0);
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL nan_ready: got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_nan !== 1'b1 || rsp_inf !== 1'b0) begin fails++; $display("FAIL nan_flags: got valid %b nan %b inf %b exp 1 1 0", rsp_valid, rsp_nan, rsp_inf); end
        tests++; if (rsp_result !== 32'h7FC00000) begin fails++; $display("FAIL nan_result: got %h exp 7fc00000", rsp_result); end
        @(negedge clk);
        set_req(0, 32'h7F800000, 32'h3F800000, 1'b1);
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL inf_ready: got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_inf !== 1'b1 || rsp_nan !== 1'b0) begin fails++; $display("FAIL inf_flags: got valid %b nan %b inf %b exp 1 0 1", rsp_valid, rsp_nan, rsp_inf); end
        tests++; if (rsp_result !== 32'h7F800000) begin fails++; $display("FAIL inf_result: got %h exp 7f800000", rsp_result); end
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        bit seen;
        set_all_req();
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin fails++; $display("FAIL rst_pre: got busy %b valid %b exp 1 1", busy, rsp_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_async: got valid %b busy %b exp 0 0", rsp_valid, busy); end
        tests++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_op !== 1'b0) begin fails++; $display("FAIL rst_fpu: got %h %h %b exp 0 0 0", fpu_a, fpu_b, fpu_op); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_ghost: got response after reset %b exp 0", seen); end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rst_ptr: got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_req2();
        test_round_robin();
        test_backpressure();
        test_flags();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
